twiddle_request_sequencer: RTL
==============================

Name: twiddle_request_sequencer

Overview:
- Initiator side of the FFT twiddle-angle interface. Walks every radix-2 DIT butterfly of an N-point FFT, stage by stage.
- For each distinct twiddle, it issues (n, stage, inv) requests to the angle generator LUT and captures the returned angle.
- It presents butterfly operand addresses plus the angle to the butterfly datapath over a valid/ready handshake.
- It sits between the FFT top-level control (start/done) and the angle generator / butterfly unit.

Parameters:
- N, 32, FFT size (power of two, at least 4).
- LOG2N, 5, log2(N); number of stages.
- ANG_W, 16, width of the angle word returned by the generator.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; begins a transform when idle
- inv  input  1  inverse-FFT select; sampled at accepted start
- busy  output  1  high from accepted start until done
- done  output  1  one-cycle pulse after last butterfly accepted
- ang_req_valid  output  1  one-cycle request strobe to angle generator
- ang_req_n  output  LOG2N  twiddle exponent k
- ang_req_stage  output  3  current stage s
- ang_req_inv  output  1  latched inv
- ang_rsp_valid  input  1  angle generator response strobe
- ang_rsp_angle  input  ANG_W  returned angle
- bf_valid  output  1  butterfly descriptor valid
- bf_ready  input  1  butterfly unit accepts descriptor
- bf_addr_a  output  LOG2N  top operand address
- bf_addr_b  output  LOG2N  bottom operand address
- bf_angle  output  ANG_W  captured angle
- bf_stage  output  3  stage of descriptor
- bf_last  output  1  high on final descriptor of transform

Behaviour:
- Reset (async, any state): FSM to IDLE. All outputs 0; counters s, j, g and the angle register cleared.
- Loop order per stage s (0..LOG2N-1):
  - half = 2^s, groups = N/(2*half).
  - Outer loop j = 0..half-1, inner loop g = 0..groups-1.
  - addr_a = g*2*half + j; addr_b = addr_a + half.
  - k = j << (LOG2N-1-s), truncated to LOG2N bits.
  - Count per stage: N/2 descriptors and half requests. Totals for N=32: 80 descriptors, 31 requests.
- FSM states:
  - IDLE: busy=0. start=1 latches inv, clears s/j/g, sets busy=1 and goes to REQ. start is ignored in every other state.
  - REQ: ang_req_valid=1 for exactly one cycle, with n=k, stage=s, inv=latched. Then go to WAIT.
  - WAIT: hold until ang_rsp_valid. Capture ang_rsp_angle into the angle register (same edge), then go to ISSUE. No timeout. ang_rsp_valid in any state other than WAIT is ignored.
  - ISSUE: bf_valid=1 with addresses, angle, stage and bf_last. All bf_* outputs stay stable while bf_ready=0. On bf_valid&&bf_ready:
    - if g<groups-1: g++, stay in ISSUE (angle reused; next descriptor valid the following cycle).
    - else if j<half-1: g=0, j++, go to REQ.
    - else if s<LOG2N-1: g=0, j=0, s++, go to REQ.
    - else go to DONE.
  - DONE: done=1 for one cycle, busy=0 from the next cycle, go to IDLE.
- bf_last = (s==LOG2N-1) && (j==half-1) && (g==groups-1).
- Latency:
  - accepted start -> ang_req_valid on the next cycle.
  - ang_rsp_valid -> bf_valid on the next cycle.
  - final handshake -> done on the next cycle.
- Address arithmetic is unsigned, LOG2N bits wide; no overflow occurs for legal N.
- bf_valid is 0 outside ISSUE. ang_req_* fields are 0 when ang_req_valid=0.

Test Plan:
- Reset/idle: assert reset mid-cycle with no clock -> all outputs 0 immediately. Hold idle 10 cycles -> no requests, busy=0.
- Stage 0 (N=32, inv=0, responder 2-cycle latency returning angle={stage,n}, bf_ready=1):
  - exactly 1 request (n=0, stage=0);
  - 16 descriptors (0,1),(2,3)...(30,31), all with angle 0.
- Stage 2 ordering:
  - requests n=0,4,8,12 in that order;
  - first five descriptors (0,4),(8,12),(16,20),(24,28) with n=0, then (1,5) after request n=4.
- Full transform:
  - 31 requests and 80 descriptors total;
  - final descriptor (15,31), stage 4, n=15, bf_last=1;
  - done pulses 1 cycle later, busy falls, and a second start runs identically.
- Backpressure and start-while-busy:
  - bf_ready low 5 cycles mid-stage -> bf_* stable throughout, no descriptor dropped or duplicated;
  - start pulsed while busy -> ignored;
  - inv=1 at start -> ang_req_inv=1 on all 31 requests, even if inv drops afterward.
- Reset mid-operation: assert reset while in WAIT (stage 3) -> immediate IDLE, outputs 0; a spurious ang_rsp_valid afterward is ignored; a new start restarts at stage 0, n=0.

Source files
------------

// File: rtl/twiddle_request_sequencer_if.sv
// Twiddle-angle and butterfly-descriptor bus between the FFT twiddle
// sequencer (master) and the angle generator / butterfly unit (slave).
interface twiddle_request_sequencer_if #(
  parameter int LOG2N = 5,
  parameter int ANG_W = 16
);
  logic             ang_req_valid;
  logic [LOG2N-1:0] ang_req_n;
  logic [2:0]       ang_req_stage;
  logic             ang_req_inv;
  logic             ang_rsp_valid;
  logic [ANG_W-1:0] ang_rsp_angle;
  logic             bf_valid;
  logic             bf_ready;
  logic [LOG2N-1:0] bf_addr_a;
  logic [LOG2N-1:0] bf_addr_b;
  logic [ANG_W-1:0] bf_angle;
  logic [2:0]       bf_stage;
  logic             bf_last;

  modport master (
    output ang_req_valid, ang_req_n, ang_req_stage, ang_req_inv,
    input  ang_rsp_valid, ang_rsp_angle,
    output bf_valid, bf_addr_a, bf_addr_b, bf_angle, bf_stage, bf_last,
    input  bf_ready
  );

  modport slave (
    input  ang_req_valid, ang_req_n, ang_req_stage, ang_req_inv,
    output ang_rsp_valid, ang_rsp_angle,
    input  bf_valid, bf_addr_a, bf_addr_b, bf_angle, bf_stage, bf_last,
    output bf_ready
  );
endinterface

// File: rtl/twiddle_request_sequencer.sv
// Twiddle request sequencer: walks every radix-2 DIT butterfly of an N-point
// FFT stage by stage, fetches one angle per distinct twiddle from the angle
// generator and hands (addr_a, addr_b, angle, stage, last) descriptors to the
// butterfly unit. Within a stage the twiddle index j is the outer loop so a
// fetched angle is reused across all groups sharing it.
module twiddle_request_sequencer #(
  parameter int N     = 32,
  parameter int LOG2N = 5,
  parameter int ANG_W = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic inv,
  output logic busy,
  output logic done,
  twiddle_request_sequencer_if.master tw
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_ISSUE, S_DONE} state_t;

  state_t           state;
  logic [2:0]       s;
  logic [LOG2N-1:0] j;
  logic [LOG2N-1:0] g;
  logic             inv_q;
  logic [ANG_W-1:0] angle_q;

  logic             last_g;
  logic             last_j;
  logic             last_s;
  logic [2:0]       nxt_s;
  logic [LOG2N-1:0] nxt_j;
  logic [LOG2N-1:0] nxt_g;

  // Butterfly span within stage st: 2^st.
  function automatic logic [LOG2N-1:0] half_of(input logic [2:0] st);
    return LOG2N'(1) << st;
  endfunction

  // Number of groups in stage st minus one: N/(2*2^st) - 1.
  function automatic logic [LOG2N-1:0] groups_m1_of(input logic [2:0] st);
    return (LOG2N'(N / 2) >> st) - LOG2N'(1);
  endfunction

  // Top operand address: g*2*half + j.
  function automatic logic [LOG2N-1:0] addr_a_of(input logic [2:0] st,
                                                 input logic [LOG2N-1:0] jj,
                                                 input logic [LOG2N-1:0] gg);
    return (gg << (st + 3'd1)) + jj;
  endfunction

  // Twiddle exponent: j scaled up to the full N-point index space.
  function automatic logic [LOG2N-1:0] k_of(input logic [2:0] st,
                                            input logic [LOG2N-1:0] jj);
    return jj << (3'(LOG2N - 1) - st);
  endfunction

  function automatic logic is_last(input logic [2:0] st,
                                   input logic [LOG2N-1:0] jj,
                                   input logic [LOG2N-1:0] gg);
    return (st == 3'(LOG2N - 1)) && (jj == half_of(st) - LOG2N'(1)) &&
           (gg == groups_m1_of(st));
  endfunction

  assign tw.bf_angle = angle_q;

  // Loop-nest advance: g innermost, then j, then stage.
  always_comb begin
    last_g = (g == groups_m1_of(s));
    last_j = (j == half_of(s) - LOG2N'(1));
    last_s = (s == 3'(LOG2N - 1));
    nxt_s  = s;
    nxt_j  = j;
    nxt_g  = g;
    if (!last_g) begin
      nxt_g = g + LOG2N'(1);
    end else if (!last_j) begin
      nxt_g = '0;
      nxt_j = j + LOG2N'(1);
    end else begin
      nxt_g = '0;
      nxt_j = '0;
      nxt_s = s + 3'd1;
    end
  end

  // Control FSM with registered request / descriptor / status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= S_IDLE;
      s                <= '0;
      j                <= '0;
      g                <= '0;
      inv_q            <= 1'b0;
      angle_q          <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      tw.ang_req_valid <= 1'b0;
      tw.ang_req_n     <= '0;
      tw.ang_req_stage <= '0;
      tw.ang_req_inv   <= 1'b0;
      tw.bf_valid      <= 1'b0;
      tw.bf_addr_a     <= '0;
      tw.bf_addr_b     <= '0;
      tw.bf_stage      <= '0;
      tw.bf_last       <= 1'b0;
    end else begin
      // Request strobe and done are single-cycle pulses.
      tw.ang_req_valid <= 1'b0;
      tw.ang_req_n     <= '0;
      tw.ang_req_stage <= '0;
      tw.ang_req_inv   <= 1'b0;
      done             <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            inv_q            <= inv;
            s                <= '0;
            j                <= '0;
            g                <= '0;
            busy             <= 1'b1;
            tw.ang_req_valid <= 1'b1;
            tw.ang_req_inv   <= inv;
            state            <= S_REQ;
          end
        end
        S_REQ: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (tw.ang_rsp_valid) begin
            angle_q      <= tw.ang_rsp_angle;
            tw.bf_valid  <= 1'b1;
            tw.bf_addr_a <= addr_a_of(s, j, g);
            tw.bf_addr_b <= addr_a_of(s, j, g) + half_of(s);
            tw.bf_stage  <= s;
            tw.bf_last   <= last_g && last_j && last_s;
            state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (tw.bf_ready) begin
            if (!last_g) begin
              // Same twiddle, next group: keep the captured angle.
              g            <= nxt_g;
              tw.bf_addr_a <= addr_a_of(nxt_s, nxt_j, nxt_g);
              tw.bf_addr_b <= addr_a_of(nxt_s, nxt_j, nxt_g) + half_of(nxt_s);
              tw.bf_stage  <= nxt_s;
              tw.bf_last   <= is_last(nxt_s, nxt_j, nxt_g);
            end else if (!(last_j && last_s)) begin
              s                <= nxt_s;
              j                <= nxt_j;
              g                <= nxt_g;
              tw.bf_valid      <= 1'b0;
              tw.ang_req_valid <= 1'b1;
              tw.ang_req_n     <= k_of(nxt_s, nxt_j);
              tw.ang_req_stage <= nxt_s;
              tw.ang_req_inv   <= inv_q;
              state            <= S_REQ;
            end else begin
              tw.bf_valid <= 1'b0;
              done        <= 1'b1;
              state       <= S_DONE;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
